// File: rtl/qpsk_tx_pkg.sv
// Shared constants for the QPSK transmit chain: PRBS9 polynomial taps and
// the +/-1 impulse encodings fed to the shaping filter.
package qpsk_tx_pkg;

    localparam int PRBS9_LEN    = 511;
    localparam int PRBS9_TAP_HI = 8;
    localparam int PRBS9_TAP_LO = 4;

    localparam logic signed [1:0] SYM_POS  = 2'sb01;
    localparam logic signed [1:0] SYM_NEG  = 2'sb11;
    localparam logic signed [1:0] SYM_ZERO = 2'sb00;

    // Bit 0 maps to +1, bit 1 maps to -1.
    function automatic logic signed [1:0] map_bit(input logic b);
        return b ? SYM_NEG : SYM_POS;
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
    function automatic logic [8:0] legal_seed(input logic [8:0] s);
        return (s == 9'd0) ? 9'h1FF : s;
    endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// PRBS9 (x^9+x^5+1) Fibonacci LFSR; emits lfsr[8] and steps only on i_advance.
module prbs9_lfsr
    import qpsk_tx_pkg::*;
#(
    parameter logic [8:0] SEED = 9'h1AA
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_advance,
    output logic       o_bit,
    output logic [8:0] o_state
);

    localparam logic [8:0] SEED_EFF = legal_seed(SEED);

    logic [8:0] lfsr;
    logic       fb;

    assign fb = lfsr[PRBS9_TAP_HI] ^ lfsr[PRBS9_TAP_LO];

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            lfsr <= SEED_EFF;
        end else if (i_advance) begin
            lfsr <= {lfsr[7:0], fb};
        end
    end

    assign o_bit   = lfsr[PRBS9_TAP_HI];
    assign o_state = lfsr;

endmodule

// File: rtl/prbs_qpsk_symbol_source.sv
// QPSK symbol source: independent PRBS9 streams for I/Q at baud rate, oversampled
// +/-1 impulses, and periodic deterministic bit-error injection for BER checking.
module prbs_qpsk_symbol_source
    import qpsk_tx_pkg::*;
#(
    parameter logic [8:0] PRBS_SEED_I   = 9'h1AA,
    parameter logic [8:0] PRBS_SEED_Q   = 9'h1FE,
    parameter int         OVERSAMP      = 4,
    parameter int         NB_ERR_PERIOD = 16,
    parameter int         NB_INJ_CNT    = 32
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_err_inj_en,
    input  logic [1:0]               i_err_sel,
    input  logic [NB_ERR_PERIOD-1:0] i_err_period,
    output logic                     o_valid,
    output logic                     o_bit_I,
    output logic                     o_bit_Q,
    output logic signed [1:0]        o_os_sym_I,
    output logic signed [1:0]        o_os_sym_Q,
    output logic                     o_prbs_wrap,
    output logic [NB_INJ_CNT-1:0]    o_inj_count
);

    localparam int              PH_W       = $clog2(OVERSAMP);
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(OVERSAMP - 1);
    localparam logic [8:0]      SEED_I_EFF = legal_seed(PRBS_SEED_I);

    logic [PH_W-1:0]          phase;
    logic [NB_ERR_PERIOD-1:0] sym_cnt;
    logic                     strobe;
    logic                     inj_hit;
    logic                     bit_i, bit_q;
    logic                     tx_i, tx_q;
    logic [8:0]               state_i;
    logic [8:0]               state_q_unused;

    assign strobe  = i_enable && (phase == '0);
    assign inj_hit = i_err_inj_en && (i_err_period != '0)
                     && (sym_cnt >= i_err_period - NB_ERR_PERIOD'(1));
    assign tx_i    = bit_i ^ (inj_hit & i_err_sel[0]);
    assign tx_q    = bit_q ^ (inj_hit & i_err_sel[1]);

    prbs9_lfsr #(.SEED(PRBS_SEED_I)) u_lfsr_i (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_advance (strobe),
        .o_bit     (bit_i),
        .o_state   (state_i)
    );

    prbs9_lfsr #(.SEED(PRBS_SEED_Q)) u_lfsr_q (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_advance (strobe),
        .o_bit     (bit_q),
        .o_state   (state_q_unused)
    );

    // Phase freezes in place while disabled so a resume keeps symbol timing.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            phase <= '0;
        end else if (i_enable) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            sym_cnt     <= '0;
            o_inj_count <= '0;
        end else if (strobe) begin
            if (inj_hit) begin
                sym_cnt <= '0;
                if ((i_err_sel != 2'b00) && (o_inj_count != '1)) begin
                    o_inj_count <= o_inj_count + NB_INJ_CNT'(1);
                end
            end else if (i_err_inj_en && (sym_cnt != '1)) begin
                sym_cnt <= sym_cnt + NB_ERR_PERIOD'(1);
            end
        end
    end

    // o_valid is a one-clock baud strobe with no back-pressure: the bits and
    // impulses are new exactly in the cycle it is high; o_bit_I/Q hold between.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_valid     <= 1'b0;
            o_prbs_wrap <= 1'b0;
            o_bit_I     <= 1'b0;
            o_bit_Q     <= 1'b0;
            o_os_sym_I  <= SYM_ZERO;
            o_os_sym_Q  <= SYM_ZERO;
        end else begin
            o_valid     <= strobe;
            o_prbs_wrap <= strobe && (state_i == SEED_I_EFF);
            if (strobe) begin
                o_bit_I    <= tx_i;
                o_bit_Q    <= tx_q;
                o_os_sym_I <= map_bit(tx_i);
                o_os_sym_Q <= map_bit(tx_q);
            end else begin
                o_os_sym_I <= SYM_ZERO;
                o_os_sym_Q <= SYM_ZERO;
            end
        end
    end

endmodule
